alu_multicycle: RTL and testbench

- Execution unit that consumes the 4-bit ALU select code produced by the ALU control decoder, together with two operands.
- AND, OR, ADD, SUB, SLT and NOP complete in one cycle.
- MUL (shift-add) and DIV (restoring, unsigned) are iterative and take WIDTH cycles.
- Sits in the EX stage. A start/busy/done handshake lets the control FSM stall while a multi-cycle op is running.

---
 rtl/alu_multicycle_if.sv | 26 ++
 rtl/alu_multicycle.sv | 140 ++++++++++++++
 tb/tb_alu_multicycle.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Operand/result bundle between the EX-stage control FSM (master) and alu_multicycle (slave).
// Handshake: start is taken on a rising edge only while busy=0; a taken start yields exactly one
// done pulse, in whose cycle result/zero/div_by_zero are valid. start while busy=1 is dropped.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, sel, a, b,
    input  result, zero, busy, done, div_by_zero
  );

  modport slave (
    input  start, sel, a, b,
    output result, zero, busy, done, div_by_zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// EX-stage ALU: single-cycle logic/arith ops plus iterative shift-add MUL and restoring
// unsigned DIV, each taking WIDTH cycles behind a start/busy/done handshake.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_multicycle_if.slave      bus,
  output logic [1:0]           dbg_state
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;
  localparam logic [3:0] SEL_MUL = 4'b0011;
  localparam logic [3:0] SEL_DIV = 4'b0100;
  localparam logic [3:0] SEL_NOP = 4'b1000;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL_RUN = 2'd1, DIV_RUN = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  // MUL: opx = shifted multiplicand, opy = shifted multiplier, acc = partial product.
  // DIV: opx = dividend shifting into quotient, opy = divisor, acc = partial remainder.
  logic [WIDTH-1:0] opx, opy, acc;
  logic [WIDTH-1:0] sc_res, mul_acc_nxt, div_rem_nxt, div_quo_nxt;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             idle, mul_start, div_start, sc_start, last;

  assign idle      = (state == IDLE);
  assign mul_start = idle && bus.start && (bus.sel == SEL_MUL);
  assign div_start = idle && bus.start && (bus.sel == SEL_DIV) && (bus.b != '0);
  assign sc_start  = idle && bus.start && !mul_start && !div_start;
  assign last      = (cnt == CW'(WIDTH - 1));
  assign bus.busy  = !idle;
  assign dbg_state = state;

  always_comb begin
    sc_res = bus.a + bus.b;
    case (bus.sel)
      SEL_AND: sc_res = bus.a & bus.b;
      SEL_OR:  sc_res = bus.a | bus.b;
      SEL_ADD: sc_res = bus.a + bus.b;
      SEL_SUB: sc_res = bus.a - bus.b;
      SEL_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      SEL_NOP: sc_res = '0;
      SEL_DIV: sc_res = '1;  // only reached with b == 0
      default: sc_res = bus.a + bus.b;
    endcase
  end

  always_comb begin
    mul_acc_nxt = acc + (opy[0] ? opx : '0);
    div_shift   = {acc, opx[WIDTH-1]};
    div_diff    = div_shift - {1'b0, opy};
    // No borrow means the divisor fits: keep the difference and shift in a 1.
    if (!div_diff[WIDTH]) begin
      div_rem_nxt = div_diff[WIDTH-1:0];
      div_quo_nxt = {opx[WIDTH-2:0], 1'b1};
    end else begin
      div_rem_nxt = div_shift[WIDTH-1:0];
      div_quo_nxt = {opx[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mul_start)      state_nxt = MUL_RUN;
        else if (div_start) state_nxt = DIV_RUN;
      end
      MUL_RUN: if (last) state_nxt = IDLE;
      DIV_RUN: if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      opx             <= '0;
      opy             <= '0;
      acc             <= '0;
      bus.result      <= '0;
      bus.zero        <= 1'b1;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (mul_start || div_start) begin
            opx <= bus.a;
            opy <= bus.b;
            acc <= '0;
            cnt <= '0;
          end else if (sc_start) begin
            bus.result      <= sc_res;
            bus.zero        <= ~|sc_res;
            bus.div_by_zero <= (bus.sel == SEL_DIV);
            bus.done        <= 1'b1;
          end
        end
        MUL_RUN: begin
          opx <= opx << 1;
          opy <= opy >> 1;
          acc <= mul_acc_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            bus.result      <= mul_acc_nxt;
            bus.zero        <= ~|mul_acc_nxt;
            bus.div_by_zero <= 1'b0;
            bus.done        <= 1'b1;
          end
        end
        DIV_RUN: begin
          opx <= div_quo_nxt;
          acc <= div_rem_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            bus.result      <= div_quo_nxt;
            bus.zero        <= ~|div_quo_nxt;
            bus.div_by_zero <= 1'b0;
            bus.done        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: a reference model pushes expected results on each
// accepted start, and a monitor pops and compares them on every done pulse.
module tb_alu_multicycle;
  localparam int W = 32;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int busy_cycles = 0;
  int done_seen   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_dbz_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    case (s)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0110: return x - y;
      4'b0111: return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      4'b0011: begin p = x * y; return p[W-1:0]; end
      4'b0100: return (y == '0) ? '1 : x / y;
      4'b1000: return '0;
      default: return x + y;
    endcase
  endfunction

  // ---------------- driver tasks (called at a negedge, return at the next negedge) ----------------
  task automatic drive(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y, input bit accepted);
    bus.start = 1'b1;
    bus.sel   = s;
    bus.a     = x;
    bus.b     = y;
    if (accepted) begin
      exp_q.push_back(model(s, x, y));
      exp_dbz_q.push_back((s == 4'b0100) && (y == '0));
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.sel   = 4'($urandom_range(0, 15));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.busy) busy_cycles++;
    if (rst_n && bus.done) begin
      done_seen++;
      check("busy_in_done", W'(bus.busy), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [W-1:0] e;
        logic         ed;
        e  = exp_q.pop_front();
        ed = exp_dbz_q.pop_front();
        check("result", bus.result, e);
        check("zero", W'(bus.zero), W'(e == '0));
        check("div_by_zero", W'(bus.div_by_zero), W'(ed));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int b0, d0;
    logic [3:0]   s;
    logic [W-1:0] x, y;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sel   = 4'b0000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("rst_result", bus.result, 0);
    check("rst_zero", W'(bus.zero), 1);
    check("rst_busy", W'(bus.busy), 0);
    check("rst_done", W'(bus.done), 0);
    check("rst_state", W'(dbg_state), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single-cycle ops
    drive(4'b0010, 7, 5, 1);
    check("add_done", W'(bus.done), 1);
    check("add_result", bus.result, 12);
    drive(4'b0110, 5, 5, 1);
    drive(4'b0111, 32'hFFFF_FFFF, 1, 1);
    drive(4'b1111, 3, 4, 1);
    drive(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 1);
    drive(4'b0001, 32'h0000_00F0, 32'h0000_0F00, 1);
    drive(4'b1000, 32'h1234, 32'h5678, 1);
    drive(4'b0111, 5, 32'h8000_0000, 1);
    @(negedge clk);

    // MUL with an ignored mid-op start
    b0 = busy_cycles;
    d0 = done_seen;
    drive(4'b0011, 32'h0001_2345, 32'h0000_0100, 1);
    check("mul_state", W'(dbg_state), 1);
    repeat (4) @(negedge clk);
    drive(4'b0010, 9, 9, 0);
    wait_done("mul");
    check("mul_busy_cycles", W'(busy_cycles - b0), 32);
    check("mul_result", bus.result, 32'h0123_4500);
    @(negedge clk);
    check("mul_done_count", W'(done_seen - d0), 1);

    // DIV exact and divide-by-zero
    b0 = busy_cycles;
    drive(4'b0100, 100, 7, 1);
    check("div_state", W'(dbg_state), 2);
    wait_done("div");
    check("div_busy_cycles", W'(busy_cycles - b0), 32);
    @(negedge clk);
    b0 = busy_cycles;
    drive(4'b0100, 100, 0, 1);
    check("dbz_done", W'(bus.done), 1);
    check("dbz_busy_cycles", W'(busy_cycles - b0), 0);
    @(negedge clk);

    // back-to-back: ADD launched in the DIV done cycle
    d0 = done_seen;
    drive(4'b0100, 32'hFFFF_FFFF, 1, 1);
    wait_done("b2b_div");
    drive(4'b0010, 1, 1, 1);
    check("b2b_add_result", bus.result, 2);
    @(negedge clk);
    check("b2b_done_count", W'(done_seen - d0), 2);

    // reset mid-op
    d0 = done_seen;
    drive(4'b0011, 32'hDEAD_BEEF, 32'h1234_5678, 1);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_dbz_q.pop_back());
    #1;
    check("midrst_busy", W'(bus.busy), 0);
    check("midrst_result", bus.result, 0);
    check("midrst_zero", W'(bus.zero), 1);
    check("midrst_state", W'(dbg_state), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_no_done", W'(done_seen - d0), 0);
    drive(4'b0010, 2, 2, 1);
    check("post_rst_add", bus.result, 4);
    @(negedge clk);

    // random mix, including undefined codes and zero divisors
    for (int i = 0; i < 30; i++) begin
      s = 4'($urandom_range(0, 15));
      if (i % 5 == 0) s = 4'b0011;
      if (i % 5 == 1) s = 4'b0100;
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom >> $urandom_range(0, 31));
      drive(s, x, y, 1);
      wait_done("rand");
    end
    @(negedge clk);

    check("queue_empty", W'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
